// File: rtl/cpu_pkg.sv
// Shared constants and state encoding for the 8-bit core pipeline.
package cpu_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned CNT_W      = 16;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } wb_state_e;

endpackage : cpu_pkg

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with enable; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : sat_counter

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: write-back select, retire counting and halt tracking.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
  parameter int unsigned REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int unsigned CNT_W      = cpu_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  ex_valid,
  input  logic [DATA_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     mem_read_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_halt,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  halted,
  output logic [CNT_W-1:0]      retire_count
);

  wb_state_e             state_q, state_d;
  logic                  wb_valid_q, wb_valid_d;
  logic                  wb_reg_write_q, wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  retire_en;
  logic [DATA_W-1:0]     wb_sel_c;

  assign wb_sel_c = ex_mem_to_reg ? mem_read_data : ex_alu_result;

  // Next-state: flush beats stall beats load; HALT only clears the valid bits.
  always_comb begin
    state_d        = state_q;
    wb_valid_d     = wb_valid_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    retire_en      = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (flush) begin
          wb_valid_d     = 1'b0;
          wb_reg_write_d = 1'b0;
          wb_rd_d        = '0;
          wb_data_d      = '0;
        end else if (!stall) begin
          wb_valid_d     = ex_valid;
          wb_reg_write_d = ex_valid & ex_reg_write & ~ex_halt;
          wb_rd_d        = ex_rd;
          wb_data_d      = wb_sel_c;
          retire_en      = ex_valid;
          if (ex_valid && ex_halt) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        wb_valid_d     = 1'b0;
        wb_reg_write_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_retire_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (retire_en),
    .count (retire_count)
  );

  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign halted       = (state_q == ST_HALT);

endmodule : mem_wb_stage
